// File: rtl/wb_pkg.sv
// Shared definitions for the writeback port arbiter: default widths,
// FIFO occupancy states and the x0 register address.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int unsigned WB_X0 = 0;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_PART  = 2'd1,
    WB_FULL  = 2'd2
  } wb_state_t;

  // Occupancy state implied by an entry count.
  function automatic wb_state_t wb_state_of(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0)          return WB_EMPTY;
    else if (cnt >= depth) return WB_FULL;
    else                   return WB_PART;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bundle: ALU request with valid/ready, load return (valid only),
// and the registered register-file write port.
interface wb_port_arbiter_if #(
  parameter int DATA_W = wb_pkg::WB_DATA_W,
  parameter int ADDR_W = wb_pkg::WB_ADDR_W
);
  // ALU handshake: a result transfers on a cycle where alu_valid and alu_ready
  // are both high; alu_ready never depends on alu_valid or mem_valid.
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/wb_sync_fifo.sv
// In-order holding FIFO for deferred ALU writebacks; head is read
// combinationally, pointers wrap modulo DEPTH (power of two).
module wb_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: load returns always win, losing ALU results
// queue in order. Optional WB_CONFLICT_CNT_EN adds the conflict_cnt output.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  wb_port_arbiter_if.slave bus,
  output wb_state_t    state_dbg
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [31:0]  conflict_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = ADDR_W + DATA_W;

  wb_state_t         state;
  logic              alu_ready;
  logic              alu_fire;
  logic              alu_wr;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_next;
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  assign alu_ready = (state != WB_FULL);
  assign alu_fire  = bus.alu_valid & alu_ready;
  assign alu_wr    = alu_fire & (bus.alu_rd != ADDR_W'(WB_X0));
  // The ALU bypasses the FIFO only when nothing else wants the port.
  assign push      = alu_wr & (bus.mem_valid | ~fifo_empty);
  assign pop       = ~bus.mem_valid & ~fifo_empty;
  assign count_next = fifo_count + CW'(push) - CW'(pop);
  assign {head_rd, head_data} = head;

  wb_sync_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.alu_rd, bus.alu_data}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WB_EMPTY;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state <= wb_state_of(32'(count_next), DEPTH);
      if (bus.mem_valid) begin
        rf_we_q    <= (bus.mem_rd != ADDR_W'(WB_X0));
        rf_waddr_q <= bus.mem_rd;
        rf_wdata_q <= bus.mem_data;
      end else if (!fifo_empty) begin
        // Queued entries never target x0, so a pop always writes.
        rf_we_q    <= 1'b1;
        rf_waddr_q <= head_rd;
        rf_wdata_q <= head_data;
      end else if (state == WB_EMPTY && alu_fire) begin
        rf_we_q    <= (bus.alu_rd != ADDR_W'(WB_X0));
        rf_waddr_q <= bus.alu_rd;
        rf_wdata_q <= bus.alu_data;
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

`ifdef WB_CONFLICT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (bus.alu_valid && (!alu_ready || bus.mem_valid || !fifo_empty)
                 && conflict_cnt != '1) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

  assign bus.alu_ready = alu_ready;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy      = (state != WB_EMPTY);
  assign state_dbg     = state;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; the conflict counter is also checked
// when WB_CONFLICT_CNT_EN is defined.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  wb_state_t state_dbg;
`ifdef WB_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_w;

  wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef WB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    check({tag, "_we"},    64'(bus.rf_we), 64'(1));
    check({tag, "_waddr"}, 64'(bus.rf_waddr), 64'(rd));
    check({tag, "_wdata"}, 64'(bus.rf_wdata), 64'(data));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_we", 64'(bus.rf_we), 64'(0));
    check("rst_waddr", 64'(bus.rf_waddr), 64'(0));
    check("rst_wdata", 64'(bus.rf_wdata), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_ready", 64'(bus.alu_ready), 64'(1));
    check("rst_state", 64'(state_dbg), 64'(WB_EMPTY));

    // Direct ALU path, one cycle latency.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h11;
    tick();
    idle_inputs();
    check_write("alu_direct", 5'd5, 32'h11);
    check("alu_direct_busy", 64'(bus.busy), 64'(0));
    tick();
    check("idle_we", 64'(bus.rf_we), 64'(0));
    check("idle_waddr_hold", 64'(bus.rf_waddr), 64'(5));

    // Same-cycle conflict: load first, ALU one cycle later.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'hB;
    tick();
    idle_inputs();
    check_write("conf_mem", 5'd7, 32'hB);
    check("conf_busy1", 64'(bus.busy), 64'(1));
    tick();
    check_write("conf_alu", 5'd3, 32'hA);
    check("conf_busy2", 64'(bus.busy), 64'(0));
    tick();
    check("conf_idle_we", 64'(bus.rf_we), 64'(0));

    // Load burst fills the FIFO and stalls the ALU.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h201;
    bus.mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rd   = 5'(10 + i);
      bus.mem_data = 32'h100 + 32'(i);
      tick();
      check_write("burst_mem", 5'(10 + i), 32'h100 + 32'(i));
      check("burst_ready", 64'(bus.alu_ready), (i == 0) ? 64'(1) : 64'(0));
      check("burst_busy", 64'(bus.busy), 64'(1));
      if (i < 2) begin
        exp_q.push_back({bus.alu_rd, bus.alu_data});
        bus.alu_rd   = 5'(i + 2);
        bus.alu_data = 32'h200 + 32'(i + 2);
      end
    end
    check("burst_state_full", 64'(state_dbg), 64'(WB_FULL));
    exp_q.push_back({5'd3, 32'h203});
    bus.mem_valid = 1'b0;
    tick();
    exp_w = exp_q.pop_front();
    check_write("drain_r1", exp_w[DATA_W +: ADDR_W], exp_w[DATA_W-1:0]);
    check("drain_ready", 64'(bus.alu_ready), 64'(1));
    check("drain_state_part", 64'(state_dbg), 64'(WB_PART));
    tick();
    bus.alu_valid = 1'b0;
    exp_w = exp_q.pop_front();
    check_write("drain_r2", exp_w[DATA_W +: ADDR_W], exp_w[DATA_W-1:0]);
    check("drain_busy_r3_held", 64'(bus.busy), 64'(1));
    tick();
    exp_w = exp_q.pop_front();
    check_write("drain_r3", exp_w[DATA_W +: ADDR_W], exp_w[DATA_W-1:0]);
    check("drain_busy_end", 64'(bus.busy), 64'(0));
    tick();
    check("drain_idle_we", 64'(bus.rf_we), 64'(0));

    // Writes to x0 are dropped and never queued.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    tick();
    idle_inputs();
    check("x0_alu_we", 64'(bus.rf_we), 64'(0));
    check("x0_alu_busy", 64'(bus.busy), 64'(0));
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h66;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h77;
    tick();
    idle_inputs();
    check("x0_mem_we", 64'(bus.rf_we), 64'(0));
    check("x0_mem_busy", 64'(bus.busy), 64'(0));
    tick();
    check("x0_after_we", 64'(bus.rf_we), 64'(0));

    // Fill the FIFO, then reset must flush it.
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    tick();
    bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
    tick();
    check("fill_state", 64'(state_dbg), 64'(WB_FULL));
    check("fill_ready", 64'(bus.alu_ready), 64'(0));
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("flush_we", 64'(bus.rf_we), 64'(0));
    check("flush_busy", 64'(bus.busy), 64'(0));
    check("flush_ready", 64'(bus.alu_ready), 64'(1));
    tick();
    check("flush_no_stale1", 64'(bus.rf_we), 64'(0));
    tick();
    check("flush_no_stale2", 64'(bus.rf_we), 64'(0));

`ifdef WB_CONFLICT_CNT_EN
    check("cnt_reset", 64'(conflict_cnt), 64'(0));
`endif
    // Three load cycles with the ALU asserting valid throughout.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'h88;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd12; bus.mem_data = 32'hC0;
    tick();
    tick();
    tick();
    bus.mem_valid = 1'b0;
`ifdef WB_CONFLICT_CNT_EN
    check("cnt_after_burst", 64'(conflict_cnt), 64'(3));
`endif
    check_write("cnt_burst_mem", 5'd12, 32'hC0);
    tick();
`ifdef WB_CONFLICT_CNT_EN
    check("cnt_during_drain", 64'(conflict_cnt), 64'(4));
`endif
    check_write("cnt_drain1", 5'd8, 32'h88);
    bus.alu_valid = 1'b0;
    tick();
    check_write("cnt_drain2", 5'd8, 32'h88);
    check("cnt_drain_busy", 64'(bus.busy), 64'(0));
    tick();
    check("cnt_idle_we", 64'(bus.rf_we), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
